// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU among NUM_REQ requesters (req_* in, alu_* to/from ALU) with a registered id-tagged result slot (rsp_* out)
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int SEL_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_rs1,
  input  logic [NUM_REQ*WIDTH-1:0]     req_rs2,
  input  logic [NUM_REQ*32-1:0]        req_imm,
  input  logic [NUM_REQ*SEL_W-1:0]     req_sel,
  input  logic [NUM_REQ*WIDTH-1:0]     req_pc,
  output logic [WIDTH-1:0]             alu_rs1,
  output logic [WIDTH-1:0]             alu_rs2,
  output logic [WIDTH-1:0]             alu_pc,
  output logic [31:0]                  alu_imm,
  output logic [SEL_W-1:0]             alu_sel,
  input  logic [WIDTH-1:0]             alu_rd,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH-1:0]             rsp_rd,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, cand, idx;
  logic found, slot_free, acc;
  always_comb begin
    cand = '0;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        cand = idx;
        found = 1'b1;
      end
    end
  end
  assign slot_free = (state == EMPTY) | rsp_ready;
  assign req_ready = (rst_n & slot_free & found) ? NUM_REQ'(1) << cand : '0;
  assign acc = |req_ready;
  assign alu_rs1 = found ? req_rs1[cand*WIDTH +: WIDTH] : '0;
  assign alu_rs2 = found ? req_rs2[cand*WIDTH +: WIDTH] : '0;
  assign alu_pc  = found ? req_pc[cand*WIDTH +: WIDTH] : '0;
  assign alu_imm = found ? req_imm[cand*32 +: 32] : '0;
  assign alu_sel = found ? req_sel[cand*SEL_W +: SEL_W] : '0;
  assign rsp_valid = (state == FULL);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      rsp_rd <= '0;
      rsp_id <= '0;
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (acc) begin
      state  <= FULL;
      rsp_rd <= alu_rd;
      rsp_id <= cand;
      rr_ptr <= cand;
    end else if (rsp_ready) begin
      state  <= EMPTY;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus with a queue scoreboard checked by an independent response monitor
module tb_alu_share_arbiter;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, LUI = 5'd2;
  typedef struct packed {logic id; logic [31:0] rd;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0, rsp_valid;
  logic [1:0] req_valid = '0, req_ready;
  logic [63:0] req_rs1 = '0, req_rs2 = '0, req_imm = '0, req_pc = '0;
  logic [9:0] req_sel = '0;
  logic [31:0] alu_rs1, alu_rs2, alu_pc, alu_imm, alu_rd, rsp_rd;
  logic [4:0] alu_sel;
  logic rsp_id;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  always_comb alu_rd = (alu_sel == ADD) ? alu_rs1 + alu_rs2 :
                       (alu_sel == SUB) ? alu_rs1 - alu_rs2 :
                       (alu_sel == LUI) ? alu_imm : 32'd0;
  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_sel(req_sel), .req_pc(req_pc),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_sel(alu_sel),
    .alu_rd(alu_rd), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_id(rsp_id)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", {rsp_id, rsp_rd}, 64'hdead);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_rd", 64'(rsp_rd), 64'(e.rd));
      end
    end
  end
  task automatic step(input logic [1:0] v, input logic rr, input logic [1:0] exp_ready,
                      input logic exp_valid, input logic [31:0] exp_rd);
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    if (exp_ready != 2'b00) q.push_back('{id: exp_ready[1], rd: exp_rd});
    @(posedge clk);
    #1;
  endtask
  initial begin
    req_rs1[0 +: 32] = 32'd5;  req_rs2[0 +: 32] = 32'd3; req_sel[0 +: 5] = ADD;
    req_rs1[32 +: 32] = 32'd10; req_rs2[32 +: 32] = 32'd4; req_sel[5 +: 5] = SUB;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) step(2'b11, 1'b1, 2'b00, 1'b0, 32'd0);
    chk("reset_rd", 64'(rsp_rd), 64'd0);
    chk("reset_id", 64'(rsp_id), 64'd0);
    rst_n = 1'b1;
    step(2'b11, 1'b1, 2'b01, 1'b0, 32'd8);
    step(2'b00, 1'b1, 2'b00, 1'b1, 32'd0);
    step(2'b00, 1'b1, 2'b00, 1'b0, 32'd0);
    step(2'b11, 1'b1, 2'b10, 1'b0, 32'd6);
    step(2'b11, 1'b1, 2'b01, 1'b1, 32'd8);
    step(2'b11, 1'b1, 2'b10, 1'b1, 32'd6);
    step(2'b11, 1'b1, 2'b01, 1'b1, 32'd8);
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b0, 2'b00, 1'b1, 32'd0);
      chk("held_rd", 64'(rsp_rd), 64'd8);
      chk("held_id", 64'(rsp_id), 64'd0);
    end
    step(2'b11, 1'b1, 2'b10, 1'b1, 32'd6);
    step(2'b00, 1'b1, 2'b00, 1'b1, 32'd0);
    step(2'b00, 1'b1, 2'b00, 1'b0, 32'd0);
    chk("alu_idle", 64'(|{alu_rs1, alu_rs2, alu_pc, alu_imm, alu_sel}), 64'd0);
    req_sel[5 +: 5] = LUI;
    req_imm[32 +: 32] = 32'h12345000;
    step(2'b10, 1'b1, 2'b10, 1'b0, 32'h12345000);
    step(2'b00, 1'b1, 2'b00, 1'b1, 32'd0);
    step(2'b00, 1'b1, 2'b00, 1'b0, 32'd0);
    step(2'b11, 1'b1, 2'b01, 1'b0, 32'd8);
    step(2'b11, 1'b1, 2'b10, 1'b1, 32'h12345000);
    step(2'b11, 1'b1, 2'b01, 1'b1, 32'd8);
    rst_n = 1'b0;
    step(2'b11, 1'b0, 2'b00, 1'b1, 32'd0);
    void'(q.pop_back());
    step(2'b11, 1'b0, 2'b00, 1'b0, 32'd0);
    chk("midop_rst_rd", 64'(rsp_rd), 64'd0);
    rst_n = 1'b1;
    step(2'b11, 1'b1, 2'b01, 1'b0, 32'd8);
    step(2'b00, 1'b1, 2'b00, 1'b1, 32'd0);
    step(2'b00, 1'b1, 2'b00, 1'b0, 32'd0);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
